// File: rtl/id_regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the ID-stage register file / scoreboard.
//   DEF_*          default parameter values used by the top and the core
//   addr_in_range  true when a register index names an implemented register
//                  (matters only when NUM_REGS is not a power of two)
package id_regfile_scoreboard_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int DEF_RD_PORTS = 2;
  localparam int DEF_MAX_PEND = 3;

  function automatic logic addr_in_range(input int addr, input int num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/id_regfile_scoreboard_core.sv
// Architectural register array: NUM_REGS x DATA_W, async active-low reset,
// one write port and RD_PORTS combinational read ports.
//   clk, rst           clock / asynchronous active-low reset
//   wr_en/addr/data    write port, takes effect on the rising edge
//   rd_addr            flat read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data            flat read data, port i at [i*DATA_W +: DATA_W]
// Indices beyond NUM_REGS read as zero and are never written.
module id_regfile_scoreboard_core
  import id_regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int RD_PORTS = DEF_RD_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_en && addr_in_range(int'(wr_addr), NUM_REGS)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] =
      addr_in_range(int'(addr), NUM_REGS) ? regs[addr] : '0;
  end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file with write-back bypass and a per-register
// pending-write scoreboard.
//   clk, rst                 clock / asynchronous active-low reset
//   rd_en, rd_addr           per-port operand valid and register index
//   rd_data, rd_busy         bypassed read data; operand still waiting on a write
//   issue_valid/wb_en/dest   instruction presented by decode and its destination
//   stall                    issue not accepted (RAW hazard or pending-count full)
//   wb_en, wb_dest, wb_value write-back from WB stage
//   flush                    drops every outstanding reservation
//   sb_err                   sticky: write-back arrived for a register with nothing pending
module id_regfile_scoreboard
  import id_regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         issue_valid,
  input  logic                         issue_wb_en,
  input  logic [ADDR_W-1:0]            issue_dest,
  output logic                         stall,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_dest,
  input  logic [DATA_W-1:0]            wb_value,
  input  logic                         flush,
  output logic                         sb_err
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]          cnt [NUM_REGS];
  logic [RD_PORTS*DATA_W-1:0] core_data;
  logic [CNT_W-1:0]          dest_cnt;
  logic [CNT_W-1:0]          wb_cnt;
  logic                      wb_ok;
  logic                      dest_full;
  logic                      issue_fire;
  logic [NUM_REGS-1:0]       inc_vec;
  logic [NUM_REGS-1:0]       dec_vec;

  id_regfile_scoreboard_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RD_PORTS (RD_PORTS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wb_en),
    .wr_addr (wb_dest),
    .wr_data (wb_value),
    .rd_addr (rd_addr),
    .rd_data (core_data)
  );

  assign wb_ok = addr_in_range(int'(wb_dest), NUM_REGS);

  // Per read port: bypass from WB, and busy unless the only pending write
  // for that register is the one arriving this cycle.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  acnt;
    logic              hit;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign acnt = addr_in_range(int'(addr), NUM_REGS) ? cnt[addr] : '0;
    assign hit  = wb_en && wb_ok && (wb_dest == addr);
    assign rd_busy[i] = rd_en[i] && (acnt != '0) && !((acnt == CNT_ONE) && hit);
    assign rd_data[i*DATA_W +: DATA_W] = hit ? wb_value : core_data[i*DATA_W +: DATA_W];
  end

  assign dest_cnt = addr_in_range(int'(issue_dest), NUM_REGS) ? cnt[issue_dest] : '0;
  assign wb_cnt   = wb_ok ? cnt[wb_dest] : '0;

  // A full counter is fine if a write-back retires one of its entries now.
  assign dest_full  = issue_wb_en && (dest_cnt == CNT_MAX) &&
                      !(wb_en && (wb_dest == issue_dest));
  assign stall      = issue_valid && ((|rd_busy) || dest_full);
  assign issue_fire = issue_valid && issue_wb_en && !stall && !flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_fire && (issue_dest == ADDR_W'(r));
      dec_vec[r] = wb_en && (wb_dest == ADDR_W'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err <= 1'b0;
    end else if (wb_en && wb_ok && (wb_cnt == '0) && !flush) begin
      sb_err <= 1'b1;
    end
  end

endmodule
